// File: rtl/filter_pkg.sv
// Shared types and constants for the IIR filter coefficient path.
package filter_pkg;

    localparam int unsigned COEF_W = 16;

    typedef logic [COEF_W-1:0] coef_t;

    localparam coef_t COEF_A_RST = 16'h0000;
    localparam coef_t COEF_B_RST = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Unsigned distance between two coefficients.
    function automatic coef_t coef_dist(input coef_t x, input coef_t y);
        return (x > y) ? coef_t'(x - y) : coef_t'(y - x);
    endfunction

endpackage

// File: rtl/filter_coef_ramp_if.sv
// Target handshake and coefficient outputs of filter_coef_ramp.
interface filter_coef_ramp_if;
    import filter_pkg::*;

    coef_t tgt_b;
    logic  tgt_valid;
    logic  tgt_ready;
    coef_t a;
    coef_t b;
    logic  busy;
    logic  upd;

    modport master (
        output tgt_b,
        output tgt_valid,
        input  tgt_ready,
        input  a,
        input  b,
        input  busy,
        input  upd
    );

    modport slave (
        input  tgt_b,
        input  tgt_valid,
        output tgt_ready,
        output a,
        output b,
        output busy,
        output upd
    );

endinterface

// File: rtl/tick_divider.sv
// Loadable down-counter; zero pulses for one cycle after each wrap through 0.
module tick_divider #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] reload,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q, zero_d;

    always_comb begin
        cnt_d  = cnt_q;
        zero_d = 1'b0;
        if (load) begin
            cnt_d = reload;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d  = reload;
                zero_d = 1'b1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/filter_coef_ramp.sv
// Glides the IIR a/b coefficient pair toward requested b targets (a = FFFF - b).
// FILTER_COEF_RAMP_EXP_EN selects exponential instead of linear glide.
module filter_coef_ramp
    import filter_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter coef_t       STEP  = 16'd64,
    parameter int unsigned SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] tick_div,
    filter_coef_ramp_if.slave bus
);

    state_e state_q, state_d;
    coef_t  b_q, b_d;
    coef_t  a_q, a_d;
    coef_t  tgt_q, tgt_d;
    coef_t  pend_q, pend_d;
    logic   pend_valid_q, pend_valid_d;
    logic   busy_q, busy_d;
    logic   upd_q, upd_d;
    logic   tgt_ready_q, tgt_ready_d;

    logic   div_load, div_en, div_zero;
    logic   xfer, done;
    coef_t  diff, step_s, move, b_step;

    logic   unused_cfg;
    assign unused_cfg = ^{STEP, SHIFT};

    tick_divider #(.W(DIV_W)) u_div (
        .clk    (clk),
        .rst    (rst),
        .load   (div_load),
        .en     (div_en),
        .reload (tick_div),
        .zero   (div_zero)
    );

    // Candidate next b: one step toward the target, never past it.
    always_comb begin
        diff = coef_dist(b_q, tgt_q);
`ifdef FILTER_COEF_RAMP_EXP_EN
        step_s = diff >> SHIFT;
        if (step_s == '0) begin
            step_s = coef_t'(1);
        end
`else
        step_s = STEP;
`endif
        move   = (step_s < diff) ? step_s : diff;
        b_step = (b_q > tgt_q) ? coef_t'(b_q - move) : coef_t'(b_q + move);
    end

    assign xfer   = bus.tgt_valid && tgt_ready_q;
    assign done   = div_zero && (b_step == tgt_q);
    assign div_en = (state_q == RAMP);

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        upd_d        = 1'b0;
        div_load     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer && (bus.tgt_b != b_q)) begin
                    tgt_d    = bus.tgt_b;
                    div_load = 1'b1;
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                if (div_zero) begin
                    b_d   = b_step;
                    upd_d = 1'b1;
                end
                if (done) begin
                    // Chain into the pending target, or a same-edge transfer, without leaving RAMP.
                    if (pend_valid_q) begin
                        pend_valid_d = 1'b0;
                        if (pend_q != b_step) begin
                            tgt_d    = pend_q;
                            div_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (xfer && (bus.tgt_b != b_step)) begin
                        tgt_d    = bus.tgt_b;
                        div_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    pend_d       = bus.tgt_b;
                    pend_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        a_d         = coef_t'(COEF_B_RST - b_d);
        tgt_ready_d = !pend_valid_d;
        // busy also covers the cycle that shows the final coefficient.
        busy_d      = (state_d == RAMP) || upd_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            b_q          <= COEF_B_RST;
            a_q          <= COEF_A_RST;
            tgt_q        <= COEF_B_RST;
            pend_q       <= COEF_B_RST;
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            upd_q        <= 1'b0;
            tgt_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            a_q          <= a_d;
            tgt_q        <= tgt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            busy_q       <= busy_d;
            upd_q        <= upd_d;
            tgt_ready_q  <= tgt_ready_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.upd       = upd_q;
    assign bus.tgt_ready = tgt_ready_q;

endmodule

// File: tb/tb_filter_coef_ramp.sv
// Self-checking bench for filter_coef_ramp against a transaction-level glide model.
module tb_filter_coef_ramp;
    import filter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tick_div = 16'd0;

    filter_coef_ramp_if ifc ();

    filter_coef_ramp #(.DIV_W(16), .STEP(16'd64), .SHIFT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_div (tick_div),
        .bus      (ifc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] obs_b[$];
    logic [15:0] obs_a[$];
    int          obs_t[$];
    int          idle_t[$];
    logic [15:0] exp_b[$];
    int          exp_t[$];

    // Observe every coefficient update and every non-busy cycle.
    always @(negedge clk) begin
        if (ifc.upd === 1'b1) begin
            obs_b.push_back(ifc.b);
            obs_a.push_back(ifc.a);
            obs_t.push_back(cyc);
        end
        if (ifc.busy !== 1'b1) idle_t.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One glide step computed directly from the distance to the target.
    function automatic logic [15:0] model_step(input logic [15:0] cur, input logic [15:0] tgt);
        int d, s;
        d = (cur > tgt) ? (int'(cur) - int'(tgt)) : (int'(tgt) - int'(cur));
`ifdef FILTER_COEF_RAMP_EXP_EN
        s = d / 16;
        if (s < 1) s = 1;
`else
        s = 64;
`endif
        if (s > d) s = d;
        return (cur > tgt) ? 16'(int'(cur) - s) : 16'(int'(cur) + s);
    endfunction

    // Expected update values/cycles for a glide started by a load at cycle k.
    task automatic model_ramp(input logic [15:0] start, input logic [15:0] tgt,
                              input int k, input int tdiv, output int last);
        logic [15:0] cur;
        int t;
        cur  = start;
        t    = k + tdiv + 2;
        last = k;
        while (cur != tgt) begin
            cur = model_step(cur, tgt);
            exp_b.push_back(cur);
            exp_t.push_back(t);
            last = t;
            t += tdiv + 1;
        end
    endtask

    task automatic clear_q();
        obs_b.delete(); obs_a.delete(); obs_t.delete();
        exp_b.delete(); exp_t.delete(); idle_t.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.tgt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, output int k);
        int n;
        n = 0;
        ifc.tgt_b     = v;
        ifc.tgt_valid = 1'b1;
        while (ifc.tgt_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready_wait", 32'(n < 5000), 32'd1);
        @(posedge clk); #1;
        k = cyc;
        ifc.tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int at);
        int n;
        n = 0;
        while (ifc.busy === 1'b1 && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_idle_wait"}, 32'(n < 20000), 32'd1);
        at = cyc;
    endtask

    task automatic check_updates(input string tag, input int k, input int last);
        int n, gaps;
        chk({tag, "_nupd"}, 32'(obs_b.size()), 32'(exp_b.size()));
        n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_b"}, 32'(obs_b[i]), 32'(exp_b[i]));
            chk({tag, "_a"}, 32'(obs_a[i]), 32'(16'hFFFF - exp_b[i]));
            chk({tag, "_t"}, 32'(obs_t[i]), 32'(exp_t[i]));
        end
        gaps = 0;
        foreach (idle_t[i]) if (idle_t[i] > k && idle_t[i] <= last) gaps++;
        chk({tag, "_busy_gap"}, 32'(gaps), 32'd0);
    endtask

    task automatic ramp(input logic [15:0] tgt, input int tdiv, input string tag);
        logic [15:0] start;
        int k, last, at;
        clear_q();
        tick_div = 16'(tdiv);
        start = ifc.b;
        send(tgt, k);
        model_ramp(start, tgt, k, tdiv, last);
        if (tgt != start) chk({tag, "_busy_rise"}, 32'(ifc.busy), 32'd1);
        wait_idle(tag, at);
        if (tgt != start) chk({tag, "_busy_drop"}, 32'(at), 32'(last + 1));
        check_updates(tag, k, last);
        chk({tag, "_final_b"}, 32'(ifc.b), 32'(tgt));
        chk({tag, "_final_a"}, 32'(ifc.a), 32'(16'hFFFF - tgt));
    endtask

    initial begin : main
        int k1, k2, l1, l2, at;
        logic [15:0] lin_exp [4];
        logic [15:0] start, v;

        // Reset values while held and right after release.
        ifc.tgt_b = 16'h0; ifc.tgt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'(ifc.a), 32'h0000);
        chk("rst_b", 32'(ifc.b), 32'hFFFF);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_upd", 32'(ifc.upd), 32'd0);
        chk("rst_ready", 32'(ifc.tgt_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready_after", 32'(ifc.tgt_ready), 32'd1);

        // Consecutive-cycle glide to FF00.
        ramp(16'hFF00, 0, "ff00");
`ifndef FILTER_COEF_RAMP_EXP_EN
        lin_exp[0] = 16'hFFBF; lin_exp[1] = 16'hFF7F; lin_exp[2] = 16'hFF3F; lin_exp[3] = 16'hFF00;
        chk("ff00_count", 32'(obs_b.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < obs_b.size()) chk("ff00_const", 32'(obs_b[i]), 32'(lin_exp[i]));
        chk("ff00_a_const", 32'(ifc.a), 32'h00FF);
`endif

        // Divided tick rate.
        do_reset();
        ramp(16'hFF37, 3, "div3");
`ifndef FILTER_COEF_RAMP_EXP_EN
        chk("div3_count", 32'(obs_b.size()), 32'd4);
`endif

        // Target equal to current b is consumed silently.
        clear_q();
        start = ifc.b;
        send(start, k1);
        repeat (10) @(posedge clk);
        #1;
        chk("same_nupd", 32'(obs_b.size()), 32'd0);
        chk("same_busy", 32'(ifc.busy), 32'd0);
        chk("same_ready", 32'(ifc.tgt_ready), 32'd1);

        // Random targets and divider settings.
        for (int r = 0; r < 6; r++) begin
            v = 16'($urandom);
            ramp(v, int'($urandom_range(0, 2)), "rand");
        end

        // Pending slot: 9000 held while gliding to 8000, then chained.
        do_reset();
        clear_q();
        tick_div = 16'd1;
        start = ifc.b;
        send(16'h8000, k1);
        repeat (3) @(posedge clk);
        #1;
        send(16'h9000, k2);
        chk("pend_ready_low", 32'(ifc.tgt_ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("pend_ready_held", 32'(ifc.tgt_ready), 32'd0);
        model_ramp(start, 16'h8000, k1, 1, l1);
        model_ramp(16'h8000, 16'h9000, l1, 1, l2);
        wait_idle("pend", at);
        chk("pend_busy_drop", 32'(at), 32'(l2 + 1));
        check_updates("pend", k1, l2);
        chk("pend_final_b", 32'(ifc.b), 32'h9000);
        chk("pend_ready_back", 32'(ifc.tgt_ready), 32'd1);

        // Reset mid-glide discards target and pending slot.
        clear_q();
        tick_div = 16'd0;
        send(16'h0000, k1);
        repeat (5) @(posedge clk);
        #1;
        send(16'h1234, k2);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(ifc.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_a", 32'(ifc.a), 32'h0000);
        chk("mid_rst_b", 32'(ifc.b), 32'hFFFF);
        chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
        chk("mid_rst_upd", 32'(ifc.upd), 32'd0);
        chk("mid_rst_ready", 32'(ifc.tgt_ready), 32'd0);
        rst = 1'b0;
        clear_q();
        repeat (40) @(posedge clk);
        #1;
        chk("mid_no_upd", 32'(obs_b.size()), 32'd0);
        chk("mid_b_hold", 32'(ifc.b), 32'hFFFF);
        chk("mid_ready", 32'(ifc.tgt_ready), 32'd1);

        // Full-range glide down to 0000.
        ramp(16'h0000, 0, "zero");
`ifdef FILTER_COEF_RAMP_EXP_EN
        if (obs_b.size() >= 2) begin
            chk("exp_first", 32'(obs_b[0]), 32'hF000);
            chk("exp_second", 32'(obs_b[1]), 32'hE100);
            chk("exp_last_step", 32'(obs_b[obs_b.size()-2]), 32'h0001);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
